// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and the receiver FSM state encoding.
// Used by uart_rx_os16; the frame defaults are also meant for tick_gen and uart_tx.
package uart_pkg;

    // Default frame shape: 8 data bits, 16 b_tick strobes per bit period.
    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;

    // Receiver FSM states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Flop-chain synchronizer for an asynchronous single-bit input.
// Flops reset to 1 so that an idle-high line never looks like it fell on reset release.
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset (presets the chain to 1)
//   d    asynchronous input
//   q    synchronized output, STAGES clocks behind d
module uart_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain_q <= '1;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver driven by a 16x-oversampling b_tick strobe.
// Samples the start bit at its centre (rejecting glitches), then each data bit and the stop
// bit one full bit period apart. Good frames update rx_data with a one-clock rx_done pulse;
// a low stop bit gives a one-clock frame_err pulse and leaves rx_data unchanged.
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   b_tick     one-clock strobe, OVERSAMPLE per bit period
//   rx         asynchronous serial line, idle high
//   rx_data    last good byte
//   rx_done    one-clock pulse, rx_data just updated
//   frame_err  one-clock pulse, stop bit sampled low
//   rx_busy    high whenever the FSM is not idle
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = UART_DATA_BITS,
    parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int unsigned BitCntW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [3:0]         TickMid = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]         TickEnd = 4'(OVERSAMPLE - 1);
    localparam logic [BitCntW-1:0] BitLast = BitCntW'(DATA_BITS - 1);

    logic rx_s;

    rx_state_e              state_q, state_d;
    logic [3:0]             tick_q, tick_d;
    logic [BitCntW-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    tick_d  = '0;
                end
            end
            StStart: begin
                if (b_tick) begin
                    if (tick_q == TickMid) begin
                        // Still low at mid-start: a real start bit, else a glitch.
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s ? StIdle : StData;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            StData: begin
                if (b_tick) begin
                    if (tick_q == TickEnd) begin
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        tick_d  = '0;
                        if (bit_q == BitLast) begin
                            state_d = StStop;
                        end else begin
                            bit_d = bit_q + BitCntW'(1);
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            StStop: begin
                if (b_tick) begin
                    if (tick_q == TickEnd) begin
                        // Leave at mid-stop so a back-to-back start edge is not missed.
                        state_d = StIdle;
                        tick_d  = '0;
                        if (rx_s) begin
                            data_d = shift_q;
                            done_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx_data   = data_q;
    assign rx_done   = done_q;
    assign frame_err = err_q;
    assign rx_busy   = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: frames are driven bit by bit, counting b_tick
// strobes (16 per bit, one strobe every 4 clocks). Each frame pushes its expected outcome
// into a queue; a monitor pops and compares whenever rx_done or frame_err pulses.
module tb_uart_rx_os16;

    logic       clk;
    logic       rst;
    logic       b_tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] last_good;
    bit         tick_en;
    int         phase;
    int         n_checks;
    int         n_errors;
    bit         prev_pulse;

    uart_rx_os16 dut (
        .clk       (clk),
        .rst       (rst),
        .b_tick    (b_tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // b_tick changes on the falling edge so every rising edge sees a stable value.
    initial begin
        b_tick = 1'b0;
        phase  = 0;
        forever begin
            @(negedge clk);
            if (tick_en) begin
                phase  = (phase + 1) % 4;
                b_tick = (phase == 0);
            end else begin
                b_tick = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ticks(input int n);
        int c = 0;
        while (c < n) begin
            @(posedge clk);
            if (b_tick) c++;
        end
    endtask

    // Hold the line at v for n bit-ticks, changing just after a tick edge.
    task automatic drive(input logic v, input int n);
        rx = v;
        wait_ticks(n);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap,
                              input int freeze_bit);
        exp_t e;
        if (stop_ok) begin
            e.is_err  = 1'b0;
            e.data    = b;
            last_good = b;
        end else begin
            e.is_err = 1'b1;
            e.data   = last_good;
        end
        exp_q.push_back(e);
        drive(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == freeze_bit) begin
                drive(b[i], 8);
                tick_en = 1'b0;
                repeat (200) @(posedge clk);
                #1;
                check("busy_during_freeze", {31'b0, rx_busy}, 32'd1);
                tick_en = 1'b1;
                drive(b[i], 8);
            end else begin
                drive(b[i], 16);
            end
        end
        if (stop_ok) begin
            drive(1'b1, 16);
        end else begin
            // Low stop bit releases early enough that the re-entered start is rejected.
            drive(1'b0, 12);
            drive(1'b1, 4);
        end
        if (gap > 0) drive(1'b1, gap);
    endtask

    // Scoreboard monitor.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rx_done || frame_err) begin
            check("done_err_exclusive", {31'b0, rx_done & frame_err}, 32'd0);
            check("pulse_one_clk", {31'b0, prev_pulse}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_event: got done=%0b err=%0b, expected none at %0t",
                         rx_done, frame_err, $time);
            end else begin
                e = exp_q.pop_front();
                check("event_kind_err", {31'b0, frame_err}, {31'b0, e.is_err});
                check("rx_data", {24'b0, rx_data}, {24'b0, e.data});
            end
        end
        prev_pulse = rx_done | frame_err;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        bit         ok;
        n_checks   = 0;
        n_errors   = 0;
        prev_pulse = 1'b0;
        last_good  = 8'h00;
        tick_en    = 1'b1;
        rst        = 1'b0;
        rx         = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_rx_data", {24'b0, rx_data}, 32'd0);
        check("reset_rx_done", {31'b0, rx_done}, 32'd0);
        check("reset_frame_err", {31'b0, frame_err}, 32'd0);
        check("reset_rx_busy", {31'b0, rx_busy}, 32'd0);
        rst = 1'b1;
        wait_ticks(4);
        #1;
        check("idle_after_release", {31'b0, rx_busy}, 32'd0);

        // 1: plain frame
        send_frame(8'h55, 1'b1, 4, -1);
        check("busy_low_after_55", {31'b0, rx_busy}, 32'd0);

        // 2: start glitch, then a good frame
        drive(1'b0, 4);
        drive(1'b1, 16);
        check("busy_low_after_glitch", {31'b0, rx_busy}, 32'd0);
        send_frame(8'h81, 1'b1, 4, -1);

        // 3: framing error keeps the previous byte
        send_frame(8'hA3, 1'b0, 8, -1);
        check("busy_low_after_ferr", {31'b0, rx_busy}, 32'd0);

        // 4: back-to-back frames
        send_frame(8'h00, 1'b1, 0, -1);
        send_frame(8'hFF, 1'b1, 4, -1);

        // 5: reset during data bit 4
        b = 8'hC7;
        drive(1'b0, 16);
        for (int i = 0; i < 4; i++) drive(b[i], 16);
        drive(b[4], 8);
        rst = 1'b0;
        #1;
        check("midreset_rx_data", {24'b0, rx_data}, 32'd0);
        check("midreset_rx_done", {31'b0, rx_done}, 32'd0);
        check("midreset_frame_err", {31'b0, frame_err}, 32'd0);
        check("midreset_rx_busy", {31'b0, rx_busy}, 32'd0);
        last_good = 8'h00;
        rx = 1'b1;
        #20;
        rst = 1'b1;
        wait_ticks(4);
        #1;
        send_frame(8'h3C, 1'b1, 4, -1);

        // 6: b_tick frozen mid-data
        send_frame(8'($urandom), 1'b1, 4, 3);

        // Randomized frames, occasional framing errors and gaps
        for (int k = 0; k < 10; k++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            send_frame(b, ok, ok ? int'($urandom_range(0, 6)) : int'($urandom_range(4, 10)), -1);
        end

        wait_ticks(40);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        check("final_busy", {31'b0, rx_busy}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
